// File: rtl/avl_bus_type.sv
// Avalon bus field widths and the burst-checker state type.
`ifndef ALV_BURST_MAX_COUNT
`define ALV_BURST_MAX_COUNT 16
`endif

package avl_bus_type;

  localparam int AVL_ADDR_W = 32;
  localparam int AVL_DATA_W = 32;
  localparam int AVL_BE_W   = AVL_DATA_W / 8;
  localparam int AVL_BCNT_W = $clog2(`ALV_BURST_MAX_COUNT + 1);

  typedef enum logic {
    BST_IDLE  = 1'b0,
    BST_BURST = 1'b1
  } burst_state_e;

endpackage

// File: rtl/i_avl_bus.sv
// Avalon-style memory bus: command channel with request_ready, plus a
// read-response channel with valid/resp_ready handshake.
interface i_avl_bus;
  import avl_bus_type::*;

  logic [AVL_ADDR_W-1:0] address;
  logic [AVL_BE_W-1:0]   byte_en;
  logic                  read;
  logic                  write;
  logic [AVL_DATA_W-1:0] write_data;
  logic                  begin_burst_transfer;
  logic [AVL_BCNT_W-1:0] burst_count;
  logic                  request_ready;
  logic [AVL_DATA_W-1:0] read_data;
  logic                  read_data_valid;
  logic                  resp_ready;

  modport slave (
    input  address, byte_en, read, write, write_data,
    input  begin_burst_transfer, burst_count, resp_ready,
    output request_ready, read_data, read_data_valid
  );

  modport master (
    output address, byte_en, read, write, write_data,
    output begin_burst_transfer, burst_count, resp_ready,
    input  request_ready, read_data, read_data_valid
  );

endinterface

// File: rtl/avl_bus_define.sv
// Build-wide Avalon bus constants shared by the bus package and any bus users.
`ifndef ALV_BURST_MAX_COUNT
`define ALV_BURST_MAX_COUNT 16
`endif

// File: rtl/avl_resp_fifo.sv
// Generic synchronous FIFO: dout shows the head combinationally, pop advances it.
// Push is ignored when full unless a pop happens in the same cycle.
module avl_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rest,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // When full, a simultaneous pop frees the head slot that wr_ptr points at.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/avl_bus_slave_ram.sv
// Avalon slave RAM; read data appears 2 cycles after acceptance via an in-flight stage and response FIFO.
// request_ready drops once FIFO + in-flight reads fill RESP_FIFO_DEPTH; AVL_SLAVE_BURST_CHECK_EN adds a burst checker.
module avl_bus_slave_ram
  import avl_bus_type::*;
#(
  parameter int MEM_WORDS       = 1024,
  parameter int RESP_FIFO_DEPTH = 4,
  parameter int SLAVE_ID        = 0
) (
  input  logic    clk,
  input  logic    rest,
  i_avl_bus.slave avl_s,
  output logic    burst_err
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = $clog2(RESP_FIFO_DEPTH) + 1;

  if (MEM_WORDS < 4 || (MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_mem_words
    $error("avl_bus_slave_ram %0d: MEM_WORDS=%0d must be a power of 2 >= 4", SLAVE_ID, MEM_WORDS);
  end
  if (RESP_FIFO_DEPTH < 2 || (RESP_FIFO_DEPTH & (RESP_FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("avl_bus_slave_ram %0d: RESP_FIFO_DEPTH=%0d must be a power of 2 >= 2", SLAVE_ID, RESP_FIFO_DEPTH);
  end

  logic [AVL_DATA_W-1:0] mem_q [MEM_WORDS];
  logic [AVL_DATA_W-1:0] rd_word_q;
  logic                  inflight_q, inflight_d;
  logic [IDX_W-1:0]      idx;
  logic                  req_rdy, accept, rd_acc, wr_acc;
  logic [CNT_W-1:0]      fifo_count, occupancy;
  logic                  fifo_empty, fifo_pop;
  logic [AVL_DATA_W-1:0] fifo_dout;

  // Counting the in-flight read guarantees it always has a FIFO slot to land in.
  assign occupancy = fifo_count + CNT_W'(inflight_q);
  assign req_rdy   = (occupancy < CNT_W'(RESP_FIFO_DEPTH));
  assign accept    = (avl_s.read || avl_s.write) && req_rdy;
  assign rd_acc    = accept && avl_s.read;
  assign wr_acc    = accept && !avl_s.read;
  assign idx       = avl_s.address[IDX_W+1:2];

  assign avl_s.request_ready = req_rdy;

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int b = 0; b < AVL_BE_W; b++) begin
        if (avl_s.byte_en[b]) mem_q[idx][8*b +: 8] <= avl_s.write_data[8*b +: 8];
      end
    end
    if (rd_acc) rd_word_q <= mem_q[idx];
  end

  assign inflight_d = rd_acc;

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) inflight_q <= 1'b0;
    else       inflight_q <= inflight_d;
  end

  assign fifo_pop = !fifo_empty && avl_s.resp_ready;

  avl_resp_fifo #(
    .DEPTH (RESP_FIFO_DEPTH),
    .WIDTH (AVL_DATA_W)
  ) u_resp_fifo (
    .clk   (clk),
    .rest  (rest),
    .push  (inflight_q),
    .pop   (fifo_pop),
    .din   (rd_word_q),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign avl_s.read_data_valid = !fifo_empty;
  assign avl_s.read_data       = fifo_empty ? '0 : fifo_dout;

`ifdef AVL_SLAVE_BURST_CHECK_EN
  burst_state_e          st_q, st_d;
  logic [AVL_ADDR_W-1:0] exp_addr_q, exp_addr_d;
  logic [AVL_BCNT_W-1:0] remain_q, remain_d;
  logic                  err_q, err_d;
  logic                  beat_ok;

  assign beat_ok = (avl_s.address == exp_addr_q) && !avl_s.begin_burst_transfer &&
                   (avl_s.burst_count == remain_q - 1'b1);

  always_comb begin
    st_d       = st_q;
    exp_addr_d = exp_addr_q;
    remain_d   = remain_q;
    err_d      = 1'b0;
    if (accept) begin
      case (st_q)
        BST_IDLE: begin
          if (avl_s.begin_burst_transfer && avl_s.burst_count != '0) begin
            st_d       = BST_BURST;
            exp_addr_d = avl_s.address + AVL_ADDR_W'(4);
            remain_d   = avl_s.burst_count;
          end
        end
        BST_BURST: begin
          if (beat_ok) begin
            exp_addr_d = exp_addr_q + AVL_ADDR_W'(4);
            remain_d   = remain_q - 1'b1;
            if (avl_s.burst_count == '0) st_d = BST_IDLE;
          end else begin
            err_d = 1'b1;
            st_d  = BST_IDLE;
          end
        end
        default: st_d = BST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      st_q       <= BST_IDLE;
      exp_addr_q <= '0;
      remain_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      st_q       <= st_d;
      exp_addr_q <= exp_addr_d;
      remain_q   <= remain_d;
      err_q      <= err_d;
    end
  end

  assign burst_err = err_q;

  logic unused_bits;
  assign unused_bits = ^{avl_s.address[AVL_ADDR_W-1:IDX_W+2], avl_s.address[1:0], 32'(SLAVE_ID)};
`else
  assign burst_err = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{avl_s.address[AVL_ADDR_W-1:IDX_W+2], avl_s.address[1:0], 32'(SLAVE_ID),
                         avl_s.begin_burst_transfer, avl_s.burst_count};
`endif

endmodule

// File: doc/avl_bus_slave_ram.md
AVL_BUS_SLAVE_RAM -- requirements
Module: avl_bus_slave_ram

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024: RAM depth in 32-bit words; power of 2, at least 4.
REQ-002 SHALL have parameter RESP_FIFO_DEPTH, default 4: read-response FIFO depth; power of 2, at least 2.
REQ-003 SHALL have parameter SLAVE_ID, default 0: identifier shown in checker messages only.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on posedge clk.
REQ-005 SHALL have port rest, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port avl_s, i_avl_bus.slave modport, which carries the following signals.
  - address, byte_en, read, write, write_data, begin_burst_transfer, burst_count: inputs.
  - request_ready, read_data, read_data_valid: outputs.
  - resp_ready: input.
REQ-007 SHALL have port burst_err, output, 1: one-cycle pulse on a burst protocol violation.

Function
REQ-008 A command SHALL be accepted on a posedge where (read||write) && request_ready; read and write both high SHALL be treated as a read.
REQ-009 Word index SHALL be address[$clog2(MEM_WORDS)+1:2]; higher address bits and address[1:0] SHALL be ignored.
REQ-010 An accepted write SHALL update, at that edge, only the bytes enabled by byte_en[3:0].
REQ-011 An accepted read SHALL return the RAM word exactly one cycle later (in-flight stage), then push it into the response FIFO.
  - Read data is always the full 32 bits, regardless of byte_en.
REQ-012 A read accepted in the cycle after a write to the same word SHALL return the newly written data.
REQ-013 read_data_valid SHALL equal FIFO not empty; read_data SHALL equal the FIFO head; the head SHALL pop on posedge where read_data_valid && resp_ready.
REQ-014 request_ready SHALL be (fifo_count + inflight) < RESP_FIFO_DEPTH.
  - It is combinational from registered state only, never from read/write.
  - Consequently no accepted read is ever dropped.
REQ-015 A push and a pop in the same cycle SHALL leave fifo_count unchanged and preserve order.
  - This SHALL also hold when the FIFO is full.
REQ-016 Writes SHALL produce no response and SHALL be accepted whenever request_ready=1.
REQ-017 Burst beats SHALL be serviced as independent word accesses; throughput SHALL be one command per cycle while request_ready=1.
REQ-018 Reads SHALL be returned strictly in acceptance order.

Reset
REQ-019 While rest=0, the following SHALL hold:
  - read_data_valid=0, read_data=0, burst_err=0.
  - FIFO and in-flight stage empty, so request_ready=1.
  - Burst checker in IDLE.
REQ-020 RAM contents SHALL NOT be cleared by reset.
REQ-021 Reset asserted mid-operation SHALL discard all pending and in-flight reads.
  - No response for them SHALL appear after reset release.

Configuration
REQ-022 Macro AVL_SLAVE_BURST_CHECK_EN, when defined, SHALL compile in the burst checker described below.
  - The FSM has states IDLE and BURST.
  - IDLE to BURST: on an accepted beat with begin_burst_transfer=1 and burst_count!=0.
  - On that transition, exp_addr is set to address+4 and remaining to burst_count.
  - In BURST, each accepted beat SHALL satisfy all of: address==exp_addr, begin_burst_transfer=0, burst_count==remaining-1.
  - After a conforming beat, exp_addr increments by 4 and remaining decrements; return to IDLE when remaining reaches 0.
  - Any mismatch SHALL pulse burst_err for one cycle (registered) and return the FSM to IDLE.
  - The offending beat is still serviced.
  - Cycles with no accepted beat SHALL leave the FSM unchanged.
REQ-023 Without AVL_SLAVE_BURST_CHECK_EN, burst_err SHALL be tied to 0 and no checker logic SHALL exist; data behaviour SHALL be identical.

Structure
REQ-024 The burst-checker state enum SHALL live in package avl_bus_type; the burst-length limit SHALL come from `ALV_BURST_MAX_COUNT in avl_bus_define.sv.
REQ-025 The response FIFO SHALL be sub-module avl_resp_fifo, with the following ports:
  - parameters DEPTH, WIDTH.
  - push, pop, din, dout, empty, count.

Verification
REQ-026 Directed test: write 0x11223344 with byte_en=1111 to addr 0x10, then read 0x10 with resp_ready=1 -> read_data=0x11223344, valid two cycles after read acceptance.
REQ-027 Directed test: write 0xAABBCCDD with byte_en=0001 over word 0x11223344 at 0x10, then read -> 0x112233DD.
REQ-028 Directed test: resp_ready=0 with back-to-back reads, DEPTH=4 -> request_ready drops after 4 reads accepted; raising resp_ready returns them in order with no loss.
REQ-029 Directed test: burst begin at 0x100 with burst_count=3, beats 0x104/0x108/0x10C with counts 2/1/0 -> burst_err stays 0 and FSM ends in IDLE.
  - Repeat with the beat at 0x108 skipped -> one burst_err pulse.
REQ-030 Directed test: assert rest while 2 reads are pending -> read_data_valid=0 and request_ready=1 after release; RAM word at 0x10 is unchanged.
REQ-031 Directed test: random traffic from avl_bus_master_sim_model against a shadow memory -> zero read mismatches over 100k cycles, with the macro both defined and undefined.
